hazard_controller: RTL and testbench

- Sequencing controller for the 5-stage RV32I pipeline.
- Generates pipeline-register enables, the PC enable and the per-stage flush (invalid) flags.
- The flush flags feed the forwarding unit's flush_ex_mem/flush_mem_wb inputs, so forwarding never sources a bubble.
- Handles three events: load-use bubbles, I/D-cache wait stalls (with independent per-cache completion latching) and EX-resolved branch/jump redirect flushes.
- Keeps saturating performance counters.

---
 rtl/hazard_controller_pkg.sv | 29 ++
 rtl/hazard_controller_sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 157 +++++++++++++++
 tb/tb_hazard_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types for the RV32I pipeline hazard controller: writeback select
// encoding, controller state and load classification.
package hazard_controller_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hzd_state_t;

    // True when the writeback value comes from memory (result not ready in EX).
    function automatic logic is_load(input regfilemux_sel_t sel);
        return (sel == lw) || (sel == lb) || (sel == lbu) || (sel == lh) || (sel == lhu);
    endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing for the 5-stage RV32I core: register enables, PC enable,
// per-stage bubble flags, cache-wait stalls, load-use bubbles and redirect flushes.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_W-1:0]     id_rs1,
    input  logic [REG_W-1:0]     id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_W-1:0]     id_ex_rd,
    input  regfilemux_sel_t      id_ex_regfile_sel,
    input  logic                 ex_redirect,
    input  logic                 icache_read,
    input  logic                 icache_resp,
    input  logic                 dcache_req,
    input  logic                 dcache_resp,
    output logic                 icache_read_gate,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic                 flush_mem_wb,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [CNT_W-1:0]     redirect_cnt
);

    hzd_state_t state, state_next;
    logic v_id, v_ex, v_mem, v_wb;
    logic i_done, d_done, br_pend;

    logic i_ok, d_ok, advance;
    logic redirect_in, redirect_eff;
    logic rs1_hit, rs2_hit, load_use;
    logic stall_inc, bubble_inc, redirect_inc;

    // Hazard detection; a redirect from a bubble in EX is not a real branch.
    always_comb begin
        i_ok         = ~icache_read | icache_resp | i_done;
        d_ok         = ~dcache_req | dcache_resp | d_done;
        advance      = i_ok & d_ok;
        redirect_in  = ex_redirect & v_ex;
        redirect_eff = redirect_in | br_pend;
        rs1_hit      = id_uses_rs1 & (id_rs1 == id_ex_rd);
        rs2_hit      = id_uses_rs2 & (id_rs2 == id_ex_rd);
        load_use     = v_id & v_ex & is_load(id_ex_regfile_sel)
                       & (id_ex_rd != REG_W'(0)) & (rs1_hit | rs2_hit);
    end

    // Enables and counter increments; a redirect discards the stalled younger op.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        stall_inc    = 1'b0;
        bubble_inc   = 1'b0;
        redirect_inc = 1'b0;
        if (!advance) begin
            stall_inc = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (redirect_eff) begin
                redirect_inc = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                if_id_en   = 1'b0;
                bubble_inc = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (!advance) state_next = MEM_WAIT;
            MEM_WAIT: if (advance)  state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            v_id    <= 1'b0;
            v_ex    <= 1'b0;
            v_mem   <= 1'b0;
            v_wb    <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            br_pend <= 1'b0;
        end else begin
            state <= state_next;
            if (!advance) begin
                if (icache_read && icache_resp) i_done  <= 1'b1;
                if (dcache_req && dcache_resp)  d_done  <= 1'b1;
                if (redirect_in)                br_pend <= 1'b1;
            end else begin
                i_done  <= 1'b0;
                d_done  <= 1'b0;
                br_pend <= 1'b0;
                v_wb    <= v_mem;
                v_mem   <= v_ex;
                if (redirect_eff) begin
                    v_ex <= 1'b0;
                    v_id <= 1'b0;
                end else if (load_use) begin
                    v_ex <= 1'b0;
                end else begin
                    v_ex <= v_id;
                    v_id <= 1'b1;
                end
            end
        end
    end

    assign icache_read_gate = ~i_done;
    assign flush_if_id      = ~v_id;
    assign flush_id_ex      = ~v_ex;
    assign flush_ex_mem     = ~v_mem;
    assign flush_mem_wb     = ~v_wb;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect_inc),
        .count (redirect_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares. Narrow counters exercise saturation.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    localparam int unsigned CNT_W = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic id_uses_rs1, id_uses_rs2;
    regfilemux_sel_t id_ex_regfile_sel;
    logic ex_redirect, icache_read, icache_resp, dcache_req, dcache_resp;
    logic icache_read_gate, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt, redirect_cnt;

    always #5 clk = ~clk;

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .id_ex_rd          (id_ex_rd),
        .id_ex_regfile_sel (id_ex_regfile_sel),
        .ex_redirect       (ex_redirect),
        .icache_read       (icache_read),
        .icache_resp       (icache_resp),
        .dcache_req        (dcache_req),
        .dcache_resp       (dcache_resp),
        .icache_read_gate  (icache_read_gate),
        .pc_en             (pc_en),
        .if_id_en          (if_id_en),
        .id_ex_en          (id_ex_en),
        .ex_mem_en         (ex_mem_en),
        .mem_wb_en         (mem_wb_en),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex),
        .flush_ex_mem      (flush_ex_mem),
        .flush_mem_wb      (flush_mem_wb),
        .stall_cnt         (stall_cnt),
        .bubble_cnt        (bubble_cnt),
        .redirect_cnt      (redirect_cnt)
    );

    typedef struct {
        string            name;
        logic [9:0]       ctl;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] bu;
        logic [CNT_W-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // ctl = {gate, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, flush_if_id..flush_mem_wb}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = exp_q.pop_front();
            got = {icache_read_gate, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};
            checks++;
            if (got !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got %b exp %b", e.name, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.st) begin
                errors++;
                $display("FAIL %s stall_cnt got %0d exp %0d", e.name, stall_cnt, e.st);
            end
            checks++;
            if (bubble_cnt !== e.bu) begin
                errors++;
                $display("FAIL %s bubble_cnt got %0d exp %0d", e.name, bubble_cnt, e.bu);
            end
            checks++;
            if (redirect_cnt !== e.rd) begin
                errors++;
                $display("FAIL %s redirect_cnt got %0d exp %0d", e.name, redirect_cnt, e.rd);
            end
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_ex_regfile_sel = alu_out;
        ex_redirect = 1'b0;
        icache_read = 1'b0; icache_resp = 1'b0;
        dcache_req = 1'b0; dcache_resp = 1'b0;
    endtask

    task automatic hazard(input regfilemux_sel_t sel, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        id_ex_regfile_sel = sel; id_ex_rd = rd;
        id_rs1 = rs1; id_uses_rs1 = u1;
        id_rs2 = rs2; id_uses_rs2 = u2;
    endtask

    // Queue the expected view of the current cycle, then move to the next cycle.
    task automatic step(input string nm, input logic [9:0] ctl, input int s, input int b, input int r);
        exp_t e;
        e.name = nm;
        e.ctl  = ctl;
        e.st   = CNT_W'(s);
        e.bu   = CNT_W'(b);
        e.rd   = CNT_W'(r);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("reset", 10'b1_11111_1111, 0, 0, 0);

        rst_n = 1'b1;
        step("rel0", 10'b1_11111_1111, 0, 0, 0);
        step("rel1", 10'b1_11111_0111, 0, 0, 0);
        step("rel2", 10'b1_11111_0011, 0, 0, 0);
        step("rel3", 10'b1_11111_0001, 0, 0, 0);
        step("rel4", 10'b1_11111_0000, 0, 0, 0);

        hazard(lw, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step("lu_x0", 10'b1_11111_0000, 0, 0, 0);
        hazard(lw, 5'd5, 5'd5, 1'b0, 5'd3, 1'b1);
        step("lu_nouse", 10'b1_11111_0000, 0, 0, 0);
        hazard(alu_out, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        step("lu_alu", 10'b1_11111_0000, 0, 0, 0);

        hazard(lw, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        step("lu_rs1", 10'b1_00111_0000, 0, 0, 0);
        step("lu_once", 10'b1_11111_0100, 0, 1, 0);
        idle();
        step("lu_rec2", 10'b1_11111_0010, 0, 1, 0);
        step("lu_rec3", 10'b1_11111_0001, 0, 1, 0);
        step("lu_rec4", 10'b1_11111_0000, 0, 1, 0);

        hazard(lhu, 5'd7, 5'd2, 1'b0, 5'd7, 1'b1);
        step("lu_rs2", 10'b1_00111_0000, 0, 1, 0);
        idle();
        step("lu2_rec1", 10'b1_11111_0100, 0, 2, 0);
        step("lu2_rec2", 10'b1_11111_0010, 0, 2, 0);
        step("lu2_rec3", 10'b1_11111_0001, 0, 2, 0);
        step("lu2_rec4", 10'b1_11111_0000, 0, 2, 0);

        icache_read = 1'b1; dcache_req = 1'b1;
        step("cw0", 10'b1_00000_0000, 0, 2, 0);
        step("cw1", 10'b1_00000_0000, 1, 2, 0);
        icache_resp = 1'b1;
        step("cw2_iresp", 10'b1_00000_0000, 2, 2, 0);
        icache_resp = 1'b0;
        step("cw3_gate", 10'b0_00000_0000, 3, 2, 0);
        step("cw4_gate", 10'b0_00000_0000, 4, 2, 0);
        dcache_resp = 1'b1;
        step("cw5_adv", 10'b0_11111_0000, 5, 2, 0);
        idle();
        step("cw6_idle", 10'b1_11111_0000, 5, 2, 0);

        dcache_req = 1'b1; ex_redirect = 1'b1;
        step("rw0_redir", 10'b1_00000_0000, 5, 2, 0);
        ex_redirect = 1'b0;
        step("rw1_pend", 10'b1_00000_0000, 6, 2, 0);
        dcache_resp = 1'b1;
        step("rw2_adv", 10'b1_11111_0000, 7, 2, 0);
        idle();
        step("rw3_flush", 10'b1_11111_1100, 7, 2, 1);
        step("rw4", 10'b1_11111_0110, 7, 2, 1);
        step("rw5", 10'b1_11111_0011, 7, 2, 1);
        step("rw6", 10'b1_11111_0001, 7, 2, 1);
        step("rw7", 10'b1_11111_0000, 7, 2, 1);

        hazard(lw, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
        ex_redirect = 1'b1;
        step("lu_redir", 10'b1_11111_0000, 7, 2, 1);
        step("redir_bubble_ex", 10'b1_11111_1100, 7, 2, 2);
        idle();
        step("rs1", 10'b1_11111_0110, 7, 2, 2);
        step("rs2", 10'b1_11111_0011, 7, 2, 2);
        step("rs3", 10'b1_11111_0001, 7, 2, 2);
        step("rs4", 10'b1_11111_0000, 7, 2, 2);

        icache_read = 1'b1; dcache_req = 1'b1;
        step("mw0_sat", 10'b1_00000_0000, 7, 2, 2);
        icache_resp = 1'b1;
        step("mw1_iresp", 10'b1_00000_0000, 7, 2, 2);
        icache_resp = 1'b0;
        step("mw2_idone", 10'b0_00000_0000, 7, 2, 2);
        rst_n = 1'b0;
        step("mw3_async_rst", 10'b1_00000_1111, 0, 0, 0);
        icache_read = 1'b0; dcache_req = 1'b0;
        step("mw4_rst_idle", 10'b1_11111_1111, 0, 0, 0);
        rst_n = 1'b1;
        icache_resp = 1'b1; dcache_resp = 1'b1;
        step("mw5_stray_resp", 10'b1_11111_1111, 0, 0, 0);
        idle();
        step("mw6", 10'b1_11111_0111, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue left %0d exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
